icache_intc_pipe: RTL and testbench
===================================

ICACHE_INTC_PIPE -- requirements
Module: icache_intc_pipe

Interface
REQ-001 Param ADDRESS_WIDTH, default 32, width of core and bank addresses.
REQ-002 Param N_CORES, default 8, number of fetch ports (1..32).
REQ-003 Param DATA_WIDTH, default 32, fetch data width.
REQ-004 Param N_CACHE_BANKS, default 4, bank count; power of two, 1..16.
REQ-005 Param BANK_SHIFT, default $clog2(DATA_WIDTH/8), LSB index of the bank-select field.
REQ-006 Param REQ_PIPE, default 1, 1 = registered slice per bank, 0 = combinational request path.
REQ-007 Param MAX_OUTST, default 2, per-core outstanding-fetch limit (1..15).
REQ-008 Param UID_WIDTH, fixed to N_CORES, one-hot core tag.
REQ-009 clk_i  in  1  clock; all state on rising edge.
REQ-010 rst_i  in  1  synchronous, active-high reset.
REQ-011 request_i  in  N_CORES  core fetch request.
REQ-012 address_i  in  N_CORES x ADDRESS_WIDTH  core fetch address.
REQ-013 grant_o  out  N_CORES  request accepted this cycle.
REQ-014 response_o  out  N_CORES  fetch data valid.
REQ-015 read_data_o  out  N_CORES x DATA_WIDTH  fetch data.
REQ-016 request_o  out  N_CACHE_BANKS  bank request.
REQ-017 address_o  out  N_CACHE_BANKS x ADDRESS_WIDTH  bank address.
REQ-018 UID_o  out  N_CACHE_BANKS x UID_WIDTH  one-hot requester tag.
REQ-019 grant_i  in  N_CACHE_BANKS  bank accepts request_o.
REQ-020 response_i  in  N_CACHE_BANKS  bank response valid.
REQ-021 read_data_i  in  N_CACHE_BANKS x DATA_WIDTH  bank response data.
REQ-022 response_UID_i  in  N_CACHE_BANKS x UID_WIDTH  tag echoed with response.
REQ-023 protocol_err_o  out  1  sticky protocol-violation flag.

Function
REQ-024 Bank select SHALL be address_i[BANK_SHIFT+log2(N_CACHE_BANKS)-1:BANK_SHIFT]; bank 0 always when N_CACHE_BANKS=1.
REQ-025 Each core SHALL keep an outstanding counter (width $clog2(MAX_OUTST+1)): +1 on grant_o, -1 on response_o, unchanged when both occur in the same cycle.
REQ-026 A core SHALL be eligible only when request_i=1 and counter<MAX_OUTST, or counter==MAX_OUTST with response_o asserted for it that cycle.
REQ-027 Each bank SHALL have a round-robin arbiter over eligible cores targeting it; priority pointer resets to 0, moves to winner+1 (mod N_CORES) only on a granted transfer, holds otherwise.
REQ-028 REQ_PIPE=0: request_o[b]=any eligible core targets b; address_o/UID_o = winner's address/one-hot; grant_o[winner]=grant_i[b], same cycle.
REQ-029 REQ_PIPE=1: per bank a slot {valid,address,uid}; winner is granted when slot empty or (valid & grant_i[b]); slot loads winner on next edge; request_o[b]=valid; latency core grant -> request_o is 1 cycle.
REQ-030 REQ_PIPE=1: slot SHALL clear on valid & grant_i[b] with no new winner; address_o/UID_o SHALL stay stable while valid & !grant_i[b].
REQ-031 At most one grant_o bit per bank per cycle; a core is granted by at most one bank per cycle.
REQ-032 response_o[k] SHALL be OR over b of response_i[b] & response_UID_i[b][k], combinational, zero added latency.
REQ-033 read_data_o[k] SHALL be read_data_i of the lowest-index bank responding with UID bit k; 0 when response_o[k]=0.
REQ-034 protocol_err_o SHALL set (next edge) on: response to a core whose counter is 0 without same-cycle grant; two banks responding to the same core in one cycle; response_UID_i not one-hot while response_i=1. Cleared only by reset.
REQ-035 Counters SHALL saturate at 0 and MAX_OUTST; no wrap.

Reset
REQ-036 While rst_i=1 at an edge: counters, slots, pointers, protocol_err_o SHALL clear to 0.
REQ-037 During and after reset until new requests: grant_o=0, request_o=0, UID_o=0, address_o=0 (REQ_PIPE=1); response_o follows REQ-032 combinationally.
REQ-038 Reset mid-transfer SHALL discard slot contents; no request_o on the cycle after reset.

Verification
REQ-039 REQ_PIPE=1, 4 banks: core 0 requests 0x0000_0004, grant_i=1 -> grant_o[0]=1 cycle 0, request_o[1]=1, address_o[1]=0x4, UID_o[1]=0x01 cycle 1.
REQ-040 Cores 0,1,2 request bank 0 continuously, grant_i=1 -> grants in order 0,1,2,0 on consecutive cycles.
REQ-041 MAX_OUTST=2, core 3 requests, no responses -> exactly 2 grants then grant_o[3]=0; one response with UID 0x08 -> third grant same cycle.
REQ-042 Bank 2 grant_i=0 for 5 cycles with slot valid -> address_o[2]/UID_o[2] unchanged, no further core grant to bank 2.
REQ-043 Banks 0 and 1 both respond with UID 0x02 -> response_o[1]=1, read_data_o[1]=read_data_i[0], protocol_err_o=1 next cycle and held.
REQ-044 rst_i=1 with slot valid and counters at 2 -> next cycle request_o=0, protocol_err_o=0, new request accepted immediately.

Source files
------------

// File: rtl/icache_intc_pipe.sv
// icache_intc_pipe: routes core instruction fetches to cache banks with per-bank round-robin and optional request slice
module icache_intc_pipe #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int N_CORES       = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int N_CACHE_BANKS = 4,
  parameter int BANK_SHIFT    = $clog2(DATA_WIDTH/8),
  parameter int REQ_PIPE      = 1,
  parameter int MAX_OUTST     = 2,
  localparam int UID_WIDTH    = N_CORES
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [N_CORES-1:0]                           request_i,
  input  logic [N_CORES-1:0][ADDRESS_WIDTH-1:0]        address_i,
  output logic [N_CORES-1:0]                           grant_o,
  output logic [N_CORES-1:0]                           response_o,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0]           read_data_o,
  output logic [N_CACHE_BANKS-1:0]                     request_o,
  output logic [N_CACHE_BANKS-1:0][ADDRESS_WIDTH-1:0]  address_o,
  output logic [N_CACHE_BANKS-1:0][UID_WIDTH-1:0]      UID_o,
  input  logic [N_CACHE_BANKS-1:0]                     grant_i,
  input  logic [N_CACHE_BANKS-1:0]                     response_i,
  input  logic [N_CACHE_BANKS-1:0][DATA_WIDTH-1:0]     read_data_i,
  input  logic [N_CACHE_BANKS-1:0][UID_WIDTH-1:0]      response_UID_i,
  output logic                                         protocol_err_o
);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam int BW = N_CACHE_BANKS > 1 ? $clog2(N_CACHE_BANKS) : 1;
  localparam int PW = N_CORES > 1 ? $clog2(N_CORES) : 1;

  logic [N_CORES-1:0][CW-1:0]                   cnt_q, cnt_d;
  logic [N_CORES-1:0][BW-1:0]                   bsel;
  logic [N_CORES-1:0]                           elig, gnt;
  logic [N_CACHE_BANKS-1:0][PW-1:0]             ptr_q, ptr_d, win;
  logic [N_CACHE_BANKS-1:0]                     any, go, vld_q, vld_d;
  logic [N_CACHE_BANKS-1:0][ADDRESS_WIDTH-1:0]  addr_q, addr_d, win_addr;
  logic [N_CACHE_BANKS-1:0][UID_WIDTH-1:0]      uid_q, uid_d, win_uid;
  logic                                         err_q, err_d;

  // lowest-index responding bank supplies the data
  always_comb begin
    response_o = '0;
    read_data_o = '0;
    for (int k = 0; k < N_CORES; k++)
      for (int b = N_CACHE_BANKS-1; b >= 0; b--)
        if (response_i[b] && response_UID_i[b][k]) begin
          response_o[k] = 1'b1;
          read_data_o[k] = read_data_i[b];
        end
  end

  always_comb begin
    for (int k = 0; k < N_CORES; k++) begin
      bsel[k] = N_CACHE_BANKS == 1 ? '0 : BW'(address_i[k] >> BANK_SHIFT);
      elig[k] = request_i[k] && (cnt_q[k] < CW'(MAX_OUTST) || response_o[k]);
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    any = '0;
    win = '0;
    win_addr = '0;
    win_uid = '0;
    for (int b = 0; b < N_CACHE_BANKS; b++)
      for (int i = 0; i < N_CORES; i++) begin
        idx = (int'(ptr_q[b]) + i) % N_CORES;
        if (!any[b] && elig[idx] && bsel[idx] == BW'(b)) begin
          any[b] = 1'b1;
          win[b] = PW'(idx);
          win_addr[b] = address_i[idx];
          win_uid[b] = UID_WIDTH'(1) << idx;
        end
      end
  end

  always_comb begin
    go = REQ_PIPE != 0 ? (~vld_q | grant_i) : grant_i;
    gnt = '0;
    ptr_d = ptr_q;
    vld_d = vld_q & ~grant_i;
    addr_d = addr_q;
    uid_d = uid_q;
    for (int b = 0; b < N_CACHE_BANKS; b++)
      if (any[b] && go[b]) begin
        gnt[win[b]] = 1'b1;
        ptr_d[b] = win[b] == PW'(N_CORES-1) ? '0 : win[b] + PW'(1);
        vld_d[b] = 1'b1;
        addr_d[b] = win_addr[b];
        uid_d[b] = win_uid[b];
      end
    grant_o = rst_i ? '0 : gnt;
    request_o = rst_i ? '0 : (REQ_PIPE != 0 ? vld_q : any);
    address_o = rst_i ? '0 : (REQ_PIPE != 0 ? addr_q : win_addr);
    UID_o = rst_i ? '0 : (REQ_PIPE != 0 ? uid_q : win_uid);
  end

  always_comb begin
    logic seen;
    seen = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int b = 0; b < N_CACHE_BANKS; b++)
      if (response_i[b] && !$onehot(response_UID_i[b])) err_d = 1'b1;
    for (int k = 0; k < N_CORES; k++) begin
      seen = 1'b0;
      for (int b = 0; b < N_CACHE_BANKS; b++)
        if (response_i[b] && response_UID_i[b][k]) begin
          if (seen) err_d = 1'b1;
          seen = 1'b1;
        end
      if (response_o[k] && cnt_q[k] == '0 && !gnt[k]) err_d = 1'b1;
      if (gnt[k] && !response_o[k] && cnt_q[k] != CW'(MAX_OUTST)) cnt_d[k] = cnt_q[k] + CW'(1);
      else if (!gnt[k] && response_o[k] && cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ptr_q <= '0;
      vld_q <= '0;
      addr_q <= '0;
      uid_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      addr_q <= addr_d;
      uid_q <= uid_d;
      err_q <= err_d;
    end
  end

  assign protocol_err_o = err_q;
endmodule

// File: tb/tb_icache_intc_pipe.sv
// tb_icache_intc_pipe: directed checks of arbitration, slicing, credit limits, response routing and error flag
module tb_icache_intc_pipe;
  logic clk = 0, rst = 1;
  logic [7:0] request_i, grant_o, response_o;
  logic [7:0][31:0] address_i, read_data_o;
  logic [3:0] request_o, grant_i, response_i;
  logic [3:0][31:0] address_o, read_data_i;
  logic [3:0][7:0] UID_o, response_UID_i;
  logic protocol_err_o;
  int n_chk = 0, n_fail = 0;

  icache_intc_pipe dut (
    .clk_i(clk), .rst_i(rst), .request_i(request_i), .address_i(address_i),
    .grant_o(grant_o), .response_o(response_o), .read_data_o(read_data_o),
    .request_o(request_o), .address_o(address_o), .UID_o(UID_o), .grant_i(grant_i),
    .response_i(response_i), .read_data_i(read_data_i), .response_UID_i(response_UID_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic clr;
    request_i = '0;
    address_i = '0;
    grant_i = '0;
    response_i = '0;
    read_data_i = '0;
    response_UID_i = '0;
  endtask

  task automatic do_reset;
    clr();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    do_reset();
    smp();
    chk("rst_grant", 64'(grant_o), 0);
    chk("rst_request", 64'(request_o), 0);
    chk("rst_uid", 64'(UID_o), 0);
    chk("rst_addr1", 64'(address_o[1]), 0);
    chk("rst_err", 64'(protocol_err_o), 0);
    // single fetch through the slice
    cyc();
    grant_i = 4'hF;
    request_i = 8'h01;
    address_i[0] = 32'h4;
    smp();
    chk("p1_grant", 64'(grant_o), 64'h01);
    chk("p1_req_c0", 64'(request_o), 0);
    cyc();
    request_i = 0;
    smp();
    chk("p1_req_c1", 64'(request_o), 64'h2);
    chk("p1_addr", 64'(address_o[1]), 64'h4);
    chk("p1_uid", 64'(UID_o[1]), 64'h01);
    chk("p1_grant_c1", 64'(grant_o), 0);
    cyc();
    response_i = 4'b0001;
    response_UID_i[0] = 8'h01;
    read_data_i[0] = 32'hDEADBEEF;
    smp();
    chk("p1_resp", 64'(response_o), 64'h01);
    chk("p1_rdata0", 64'(read_data_o[0]), 64'hDEADBEEF);
    chk("p1_rdata1", 64'(read_data_o[1]), 0);
    cyc();
    clr();
    smp();
    chk("p1_slot_clr", 64'(request_o), 0);
    chk("p1_err", 64'(protocol_err_o), 0);
    // round robin on bank 0
    do_reset();
    grant_i = 4'hF;
    request_i = 8'h07;
    smp(); chk("rr_0", 64'(grant_o), 64'h01); cyc();
    smp(); chk("rr_1", 64'(grant_o), 64'h02); cyc();
    smp(); chk("rr_2", 64'(grant_o), 64'h04); cyc();
    smp(); chk("rr_3", 64'(grant_o), 64'h01); cyc();
    // outstanding limit on core 3
    do_reset();
    grant_i = 4'hF;
    request_i = 8'h08;
    smp(); chk("lim_g1", 64'(grant_o), 64'h08); cyc();
    smp(); chk("lim_g2", 64'(grant_o), 64'h08); cyc();
    smp(); chk("lim_blk1", 64'(grant_o), 0); cyc();
    smp(); chk("lim_blk2", 64'(grant_o), 0); cyc();
    response_i = 4'b0010;
    response_UID_i[1] = 8'h08;
    smp();
    chk("lim_g3", 64'(grant_o), 64'h08);
    chk("lim_resp", 64'(response_o), 64'h08);
    cyc();
    response_i = 0;
    smp(); chk("lim_blk3", 64'(grant_o), 0); cyc();
    request_i = 0;
    response_i = 4'b0010;
    cyc();
    response_i = 0;
    request_i = 8'h08;
    smp();
    chk("lim_after_dec", 64'(grant_o), 64'h08);
    chk("lim_err", 64'(protocol_err_o), 0);
    // stalled bank 2 holds its slot
    do_reset();
    grant_i = 4'b1011;
    request_i = 8'h10;
    address_i[4] = 32'h8;
    smp(); chk("stall_g0", 64'(grant_o), 64'h10); cyc();
    address_i[4] = 32'h18;
    address_i[5] = 32'h28;
    request_i = 8'h30;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("stall_grant", 64'(grant_o), 0);
      chk("stall_addr", 64'(address_o[2]), 64'h8);
      chk("stall_uid", 64'(UID_o[2]), 64'h10);
      cyc();
    end
    grant_i = 4'hF;
    smp(); chk("stall_rel", 64'(grant_o), 64'h20); cyc();
    request_i = 0;
    smp();
    chk("stall_addr2", 64'(address_o[2]), 64'h28);
    chk("stall_uid2", 64'(UID_o[2]), 64'h20);
    // two banks answer core 1
    do_reset();
    grant_i = 4'hF;
    request_i = 8'h02;
    smp(); chk("dbl_grant", 64'(grant_o), 64'h02); cyc();
    request_i = 0;
    cyc();
    response_i = 4'b0011;
    response_UID_i[0] = 8'h02;
    response_UID_i[1] = 8'h02;
    read_data_i[0] = 32'h11111111;
    read_data_i[1] = 32'h22222222;
    smp();
    chk("dbl_resp", 64'(response_o), 64'h02);
    chk("dbl_rdata", 64'(read_data_o[1]), 64'h11111111);
    chk("dbl_err_pre", 64'(protocol_err_o), 0);
    cyc();
    clr();
    smp(); chk("dbl_err", 64'(protocol_err_o), 1); cyc();
    smp(); chk("dbl_err_hold", 64'(protocol_err_o), 1);
    // response to idle core
    do_reset();
    response_i = 4'b1000;
    response_UID_i[3] = 8'h40;
    smp(); chk("zero_err_pre", 64'(protocol_err_o), 0); cyc();
    clr();
    smp(); chk("zero_err", 64'(protocol_err_o), 1);
    // non-one-hot tag
    do_reset();
    grant_i = 4'hF;
    request_i = 8'h03;
    address_i[1] = 32'h4;
    smp(); chk("oh_grant", 64'(grant_o), 64'h03); cyc();
    clr();
    response_i = 4'b0001;
    response_UID_i[0] = 8'h03;
    read_data_i[0] = 32'hCAFE0001;
    smp();
    chk("oh_resp", 64'(response_o), 64'h03);
    chk("oh_rdata1", 64'(read_data_o[1]), 64'hCAFE0001);
    cyc();
    clr();
    smp(); chk("oh_err", 64'(protocol_err_o), 1);
    // reset mid-transfer
    do_reset();
    grant_i = 4'b1110;
    request_i = 8'h01;
    smp(); chk("mr_g1", 64'(grant_o), 64'h01); cyc();
    address_i[0] = 32'h4;
    response_i = 4'b1000;
    response_UID_i[3] = 8'h20;
    smp(); chk("mr_g2", 64'(grant_o), 64'h01); cyc();
    clr();
    smp();
    chk("mr_slot0", 64'(request_o[0]), 1);
    chk("mr_err_set", 64'(protocol_err_o), 1);
    rst = 1;
    smp();
    chk("mr_rst_req", 64'(request_o), 0);
    chk("mr_rst_grant", 64'(grant_o), 0);
    cyc();
    rst = 0;
    grant_i = 4'hF;
    request_i = 8'h01;
    smp();
    chk("mr_req_after", 64'(request_o), 0);
    chk("mr_err_after", 64'(protocol_err_o), 0);
    chk("mr_grant_after", 64'(grant_o), 64'h01);
    cyc();
    request_i = 0;
    smp();
    chk("mr_req_next", 64'(request_o), 64'h1);
    chk("mr_uid_next", 64'(UID_o[0]), 64'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
